// File: rtl/vid_timing_pkg.sv
// rtl/vid_timing_pkg.sv - shared raster constants, totals and controller state encoding
package vid_timing_pkg;

  localparam int AXIS_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int calcTotal(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vtState_e;

endpackage

// File: rtl/video_timing_ctrl_axis.sv
// rtl/video_timing_ctrl_axis.sv - wrap counter for one raster axis with next-value region flags
module timing_axis
  import vid_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [AXIS_W-1:0] loadVal,
  input  logic              adv,
  output logic [AXIS_W-1:0] count,
  output logic [AXIS_W-1:0] nextCount,
  output logic              wrap,
  output logic              activeNext,
  output logic              syncNext
);

  localparam logic [AXIS_W-1:0] LAST = AXIS_W'(TOTAL - 1);

  // Flags describe nextCount so the parent can register them alongside the count.
  always_comb begin
    wrap = (count == LAST);
    nextCount = count;
    if (clr)
      nextCount = '0;
    else if (load)
      nextCount = loadVal;
    else if (adv)
      nextCount = wrap ? '0 : count + AXIS_W'(1);
    activeNext = int'(nextCount) < ACTIVE;
    syncNext = (int'(nextCount) >= SYNC_START) && (int'(nextCount) < SYNC_START + SYNC_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= nextCount;
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster timing, lead-timed pixel request and frame-boundary start/stop
module video_timing_ctrl
  import vid_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   FETCH_LEAD = 2
) (
  input  logic              pixclkI,
  input  logic              rstI,
  input  logic              enI,
  output logic              runningO,
  output logic              hSyncO,
  output logic              vSyncO,
  output logic              DrawAreaO,
  output logic              pixReqO,
  output logic [AXIS_W-1:0] xO,
  output logic [AXIS_W-1:0] yO,
  output logic              frameStartO,
  output logic              lineStartO
);

  localparam int H_TOTAL = calcTotal(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calcTotal(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  vtState_e state, nextState;
  logic startGo, stopGo, runNext;
  logic hWrap, vWrap, hActiveNext, vActiveNext, hSyncNext, vSyncNext;
  logic [AXIS_W-1:0] hNext, vNext;
  logic leadWraps, nextLineActive, reqNext;
  int leadH;

  always_comb begin
    nextState = state;
    startGo = 1'b0;
    stopGo = 1'b0;
    if (state == IDLE) begin
      startGo = enI;
      if (enI) nextState = RUN;
    end else if (hWrap && (int'(yO) == V_ACTIVE - 1) && !enI) begin
      stopGo = 1'b1;
      nextState = IDLE;
    end
    runNext = (nextState == RUN);
  end

  always_ff @(posedge pixclkI) begin
    if (rstI)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Starting at the top of vertical blanking gives first-frame requests their full lead.
  timing_axis #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FRONT), .SYNC_LEN(H_SYNC)
  ) hAxis (
    .clk(pixclkI), .rst(rstI), .clr(stopGo), .load(startGo), .loadVal('0),
    .adv(state == RUN), .count(xO), .nextCount(hNext), .wrap(hWrap),
    .activeNext(hActiveNext), .syncNext(hSyncNext)
  );

  timing_axis #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FRONT), .SYNC_LEN(V_SYNC)
  ) vAxis (
    .clk(pixclkI), .rst(rstI), .clr(stopGo), .load(startGo), .loadVal(AXIS_W'(V_ACTIVE)),
    .adv((state == RUN) && hWrap), .count(yO), .nextCount(vNext), .wrap(vWrap),
    .activeNext(vActiveNext), .syncNext(vSyncNext)
  );

  // Request looks FETCH_LEAD pixels ahead; past the line end it belongs to the following line.
  always_comb begin
    leadH = int'(hNext) + FETCH_LEAD;
    leadWraps = leadH >= H_TOTAL;
    if (leadWraps) leadH = leadH - H_TOTAL;
    nextLineActive = (int'(vNext) == V_TOTAL - 1) || (int'(vNext) < V_ACTIVE - 1);
    reqNext = (leadH < H_ACTIVE) && (leadWraps ? nextLineActive : vActiveNext);
  end

  always_ff @(posedge pixclkI) begin
    if (rstI) begin
      runningO    <= 1'b0;
      hSyncO      <= ~H_SYNC_POL;
      vSyncO      <= ~V_SYNC_POL;
      DrawAreaO   <= 1'b0;
      pixReqO     <= 1'b0;
      frameStartO <= 1'b0;
      lineStartO  <= 1'b0;
    end else begin
      runningO    <= runNext;
      hSyncO      <= (runNext && hSyncNext) ? H_SYNC_POL : ~H_SYNC_POL;
      vSyncO      <= (runNext && vSyncNext) ? V_SYNC_POL : ~V_SYNC_POL;
      DrawAreaO   <= runNext && hActiveNext && vActiveNext;
      pixReqO     <= runNext && reqNext;
      frameStartO <= runNext && (state == RUN) && hWrap && vWrap;
      lineStartO  <= runNext && (hNext == '0) && vActiveNext;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - self-checking bench for video_timing_ctrl on a reduced raster
module tb_video_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = 16;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = 11;
  localparam int FRAME = HT * VT;
  localparam int LEAD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic runningO, hSyncO, vSyncO, DrawAreaO, pixReqO, frameStartO, lineStartO;
  logic [11:0] xO, yO;
  logic run0, hs0, vs0, draw0, req0, fs0, ls0;
  logic [11:0] x0, y0;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FETCH_LEAD(LEAD)
  ) dut (
    .pixclkI(clk), .rstI(rst), .enI(en), .runningO(runningO), .hSyncO(hSyncO), .vSyncO(vSyncO),
    .DrawAreaO(DrawAreaO), .pixReqO(pixReqO), .xO(xO), .yO(yO),
    .frameStartO(frameStartO), .lineStartO(lineStartO)
  );

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FETCH_LEAD(0)
  ) dut0 (
    .pixclkI(clk), .rstI(rst), .enI(en), .runningO(run0), .hSyncO(hs0), .vSyncO(vs0),
    .DrawAreaO(draw0), .pixReqO(req0), .xO(x0), .yO(y0),
    .frameStartO(fs0), .lineStartO(ls0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: linear position within the frame, start/stop decided at the documented points.
  bit mRun = 1'b0;
  int mPos = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mRun <= 1'b0;
      mPos <= 0;
    end else if (!mRun) begin
      if (en) begin
        mRun <= 1'b1;
        mPos <= VA * HT;
      end
    end else if (mPos == VA * HT - 1 && !en) begin
      mRun <= 1'b0;
      mPos <= 0;
    end else begin
      mPos <= (mPos + 1) % FRAME;
    end
  end

  function automatic bit isDraw(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int h, v;
    logic [35:0] expV, gotV;
    h = mRun ? mPos % HT : 0;
    v = mRun ? mPos / HT : 0;
    expV = {mRun,
            (mRun && h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1,
            (mRun && v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1,
            mRun && isDraw(mPos),
            mRun && isDraw((mPos + LEAD) % FRAME),
            12'(h), 12'(v),
            mRun && mPos == 0,
            mRun && h == 0 && v < VA,
            mRun && isDraw(mPos),
            mRun && isDraw(mPos),
            mRun && isDraw(mPos)};
    gotV = {runningO, hSyncO, vSyncO, DrawAreaO, pixReqO, xO, yO,
            frameStartO, lineStartO, req0, draw0, {run0 & (x0 == xO) & (y0 == yO) & isDraw(mPos)}};
    checks++;
    if (gotV !== expV) begin
      errors++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, gotV, expV);
    end
  end

  task automatic startCheck(input string tag);
    int n;
    @(negedge clk);
    check({tag, "_running"}, runningO, 1);
    check({tag, "_x"}, xO, 0);
    check({tag, "_y"}, yO, VA);
    n = 0;
    while (!DrawAreaO && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_first_draw_latency"}, n, (VT - VA) * HT);
    check({tag, "_frame_start"}, frameStartO, 1);
  endtask

  task automatic frameCount();
    int nd, nr, nh, nv, nl;
    nd = 0; nr = 0; nh = 0; nv = 0; nl = 0;
    for (int i = 0; i < FRAME; i++) begin
      nd += int'(DrawAreaO);
      nr += int'(pixReqO);
      nh += int'(!hSyncO);
      nv += int'(!vSyncO);
      nl += int'(lineStartO);
      if (xO == 12'd14 && yO == 12'd10) check("req_lead_next_frame", pixReqO, 1);
      if (xO == 12'd5 && yO == 12'd5) check("req_last_lead", pixReqO, 1);
      if (xO == 12'd6 && yO == 12'd5) check("req_after_lead", pixReqO, 0);
      @(negedge clk);
    end
    check("draw_per_frame", nd, 48);
    check("req_per_frame", nr, 48);
    check("hsync_low_per_frame", nh, 33);
    check("vsync_low_per_frame", nv, 32);
    check("linestart_per_frame", nl, 6);
  endtask

  initial begin
    int n, px, py;
    rst = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_hsync", hSyncO, 1);
    check("idle_vsync", vSyncO, 1);
    check("idle_running", runningO, 0);
    check("idle_draw", DrawAreaO, 0);

    en = 1'b1;
    startCheck("start");
    frameCount();
    check("continuous_through_stop_point", runningO, 1);

    n = 0;
    while (!(yO == 12'd2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_line2_bound", int'(n < 1000), 1);
    en = 1'b0;
    n = 0; px = -1; py = -1;
    while (runningO && n < 1000) begin
      px = int'(xO);
      py = int'(yO);
      @(negedge clk);
      n++;
    end
    check("stop_reached_idle", runningO, 0);
    check("stop_last_x", px, HT - 1);
    check("stop_last_y", py, VA - 1);

    en = 1'b1;
    n = 0;
    while (!(runningO && yO == 12'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_line3_bound", int'(n < 1000), 1);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (FRAME) @(negedge clk);
    check("pulse_ignored_running", runningO, 1);

    n = 0;
    while (!(runningO && xO == 12'd5 && yO == 12'd2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_midline_bound", int'(n < 1000), 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_running", runningO, 0);
    check("reset_x", xO, 0);
    check("reset_y", yO, 0);
    check("reset_hsync", hSyncO, 1);
    rst = 1'b0;
    startCheck("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
